// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-high patterns ordered g..a (bit6=g .. bit0=a).
// Used by both the segment driver and the scan decoder so the two stay in lockstep.
package seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1111100;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0111001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1011110;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b1110001;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // Result of decoding one settled digit.
  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       err;
  } seg_dec_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the hex-to-segment table: active-high g..a pattern in,
// nibble plus blank/error classification out.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       nibble,
  output logic             is_blank,
  output logic             is_err
);

  always_comb begin
    nibble   = 4'h0;
    is_blank = 1'b0;
    is_err   = 1'b0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: is_blank = 1'b1;
      default:   is_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed active-low seven-segment bus and recovers the displayed hex frame.
// Define SEGDEC_SYNC_EN to insert a two-flop synchronizer on seg/an for external pins.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SEG_W-1:0]    seg,
  input  logic [NDIG-1:0]     an,
  output logic [4*NDIG-1:0]   hex_word,
  output logic [NDIG-1:0]     blank,
  output logic [NDIG-1:0]     err,
  output logic                frame_valid
);

  localparam int          SW      = NDIG + SEG_W;
  localparam logic [7:0]  CNT_MAX = 8'(STABLE_CYC);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= CNT_MAX) ? v : v + 8'd1;
  endfunction

  logic [SW-1:0] sample;

`ifdef SEGDEC_SYNC_EN
  // Synchronizer stages; reset to all-ones so the bus looks idle (everything off).
  logic [SW-1:0] sync_p0;
  logic [SW-1:0] sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= {an, seg};
      sync_p1 <= sync_p0;
    end
  end

  assign sample = sync_p1;
`else
  assign sample = {an, seg};
`endif

  logic [SW-1:0]      prev_p1;
  logic [7:0]         cnt_p1;
  logic [4*NDIG-1:0]  shadow_hex;
  logic [NDIG-1:0]    shadow_blank;
  logic [NDIG-1:0]    shadow_err;
  logic [NDIG-1:0]    captured;

  logic               same;
  logic [7:0]         cnt_next;
  logic               accept;
  logic [NDIG-1:0]    sel;
  logic               capture;
  logic               emit;
  logic [NDIG-1:0]    cap_base;
  seg_dec_t           dec;

  // Stability filter: accept only on the edge the run length first reaches STABLE_CYC.
  assign same     = (sample == prev_p1);
  assign cnt_next = same ? sat_inc(cnt_p1) : 8'd1;
  assign accept   = same && (cnt_p1 == (CNT_MAX - 8'd1));

  assign sel      = ~sample[SW-1:SEG_W];
  assign capture  = accept && $onehot(sel);
  assign emit     = &captured;
  assign cap_base = emit ? '0 : captured;

  seg_pattern_decode u_decode (
    .pattern  (~sample[SEG_W-1:0]),
    .nibble   (dec.nibble),
    .is_blank (dec.blank),
    .is_err   (dec.err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_p1      <= '0;
      cnt_p1       <= '0;
      shadow_hex   <= '0;
      shadow_blank <= '0;
      shadow_err   <= '0;
      captured     <= '0;
      hex_word     <= '0;
      blank        <= '0;
      err          <= '0;
      frame_valid  <= 1'b0;
    end else begin
      prev_p1     <= sample;
      cnt_p1      <= cnt_next;
      frame_valid <= emit;

      // Emission publishes the pre-edge shadow; a same-edge capture lands in the next frame.
      if (emit) begin
        hex_word <= shadow_hex;
        blank    <= shadow_blank;
        err      <= shadow_err;
      end

      if (capture) begin
        for (int i = 0; i < NDIG; i++) begin
          if (sel[i]) begin
            shadow_hex[4*i +: 4] <= dec.nibble;
            shadow_blank[i]      <= dec.blank;
            shadow_err[i]        <= dec.err;
          end
        end
        captured <= cap_base | sel;
      end else begin
        captured <= cap_base;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scans, a decode table and random
// bus activity compared cycle by cycle against a run-length based reference model.
module tb_seg_scan_decoder;

  localparam int NDIG = 4;
  localparam int K    = 4;
`ifdef SEGDEC_SYNC_EN
  localparam int LAT  = 2;
`else
  localparam int LAT  = 0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [6:0]          seg;
  logic [NDIG-1:0]     an;
  logic [4*NDIG-1:0]   hex_word;
  logic [NDIG-1:0]     blank;
  logic [NDIG-1:0]     err;
  logic                frame_valid;

  seg_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(K)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .hex_word    (hex_word),
    .blank       (blank),
    .err         (err),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent copy of the display table, active-high g..a.
  logic [6:0] tbl [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                           7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                           7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                           7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  // Reference model state
  logic [10:0]  last_s, h1, h2;
  int           run_len;
  int           m_nib [NDIG];
  bit           m_blk [NDIG];
  bit           m_er  [NDIG];
  bit           m_cap [NDIG];
  logic [15:0]  m_hex;
  logic [3:0]   m_blank, m_err;
  logic         m_fv;
  int           m_frames;

  // Bench observations
  int           cyc_idx = 0;
  int           fv_cnt  = 0;
  int           fv_at   = -1;
  logic [15:0]  last_hex;
  logic [3:0]   last_blank, last_err;

  task automatic model_reset();
    last_s = '0; h1 = '1; h2 = '1; run_len = 0;
    for (int d = 0; d < NDIG; d++) begin
      m_nib[d] = 0; m_blk[d] = 0; m_er[d] = 0; m_cap[d] = 0;
    end
    m_hex = '0; m_blank = '0; m_err = '0; m_fv = 0;
  endtask

  task automatic decode(input logic [6:0] p, output int n, output bit b, output bit e);
    n = 0; b = 0; e = 1;
    if (p == 7'b0) begin
      b = 1; e = 0;
    end else begin
      for (int v = 0; v < 16; v++)
        if (p == tbl[v]) begin n = v; e = 0; end
    end
  endtask

  task automatic model_edge(input logic [10:0] raw);
    logic [10:0] s;
    bit all;
    int zeros, dsel, n;
    bit b, e;
`ifdef SEGDEC_SYNC_EN
    s = h2; h2 = h1; h1 = raw;
`else
    s = raw;
`endif
    run_len = (s == last_s) ? run_len + 1 : 1;
    last_s = s;
    all = 1;
    for (int d = 0; d < NDIG; d++) all &= m_cap[d];
    m_fv = all;
    if (all) begin
      for (int d = 0; d < NDIG; d++) begin
        m_hex[4*d +: 4] = 4'(m_nib[d]);
        m_blank[d] = m_blk[d];
        m_err[d] = m_er[d];
        m_cap[d] = 0;
      end
      m_frames++;
    end
    if (run_len == K) begin
      zeros = 0; dsel = 0;
      for (int d = 0; d < NDIG; d++)
        if (!s[7+d]) begin zeros++; dsel = d; end
      if (zeros == 1) begin
        decode(~s[6:0], n, b, e);
        m_nib[dsel] = n; m_blk[dsel] = b; m_er[dsel] = e; m_cap[dsel] = 1;
      end
    end
  endtask

  task automatic cyc(input logic [3:0] a, input logic [6:0] s);
    @(negedge clk);
    an = a; seg = s;
    @(posedge clk);
    model_edge({a, s});
    #1;
    chk("hex_word", 32'(hex_word), 32'(m_hex));
    chk("blank", 32'(blank), 32'(m_blank));
    chk("err", 32'(err), 32'(m_err));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    if (frame_valid) begin
      fv_cnt++; fv_at = cyc_idx;
      last_hex = hex_word; last_blank = blank; last_err = err;
    end
    cyc_idx++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'b1111, 7'b1111111);
  endtask

  // Show active-high pattern p on digit d for n cycles.
  task automatic show(input int d, input logic [6:0] p, input int n);
    logic [3:0] a;
    a = ~(4'b0001 << d);
    for (int i = 0; i < n; i++) cyc(a, ~p);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_hex"}, 32'(hex_word), 0);
    chk({tag, "_blank"}, 32'(blank), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_fv"}, 32'(frame_valid), 0);
  endtask

  typedef struct {
    logic [6:0] pat;
    logic [3:0] nib;
    logic       blk;
    logic       er;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int start, base;
    for (int v = 0; v < 16; v++) vecs[v] = '{tbl[v], 4'(v), 1'b0, 1'b0};
    vecs[16] = '{7'b0000000, 4'h0, 1'b1, 1'b0};
    vecs[17] = '{7'b0101010, 4'h0, 1'b0, 1'b1};
    vecs[18] = '{7'b1000000, 4'h0, 1'b0, 1'b1};
    vecs[19] = '{7'b0111110, 4'h0, 1'b0, 1'b1};

    m_frames = 0;
    rst_n = 1'b0; an = '1; seg = '1;
    model_reset();
    #1;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Digits 1,2,3,4 -> one frame of 4321 at a known latency
    start = cyc_idx; base = fv_cnt;
    show(0, tbl[1], 6); show(1, tbl[2], 6); show(2, tbl[3], 6); show(3, tbl[4], 6);
    idle(4);
    chk("t1_frames", 32'(fv_cnt - base), 1);
    chk("t1_hex", 32'(last_hex), 32'h4321);
    chk("t1_blank", 32'(last_blank), 0);
    chk("t1_err", 32'(last_err), 0);
    chk("t1_latency", 32'(fv_at - start), 32'(22 + LAT));

    // Short glitch of "8" must be dropped, "F" wins
    base = fv_cnt;
    show(0, tbl[8], 3); show(0, tbl[15], 5);
    show(1, tbl[0], 6); show(2, tbl[0], 6); show(3, tbl[0], 6);
    idle(4);
    chk("t2_frames", 32'(fv_cnt - base), 1);
    chk("t2_hex", 32'(last_hex), 32'h000F);

    // Blank and illegal pattern classification
    base = fv_cnt;
    show(0, tbl[0], 6); show(1, 7'b0101010, 6); show(2, 7'b0000000, 6); show(3, tbl[7], 6);
    idle(4);
    chk("t3_frames", 32'(fv_cnt - base), 1);
    chk("t3_hex", 32'(last_hex), 32'h7000);
    chk("t3_blank", 32'(last_blank), 32'b0100);
    chk("t3_err", 32'(last_err), 32'b0010);

    // Multi-low anode selection is ignored
    base = fv_cnt;
    for (int i = 0; i < 10; i++) cyc(4'b0011, ~tbl[5]);
    idle(4);
    chk("t4_no_frame", 32'(fv_cnt - base), 0);
    show(0, tbl[1], 6); show(1, tbl[2], 6); show(2, tbl[3], 6); show(3, tbl[4], 6);
    idle(4);
    chk("t4_frames", 32'(fv_cnt - base), 1);
    chk("t4_hex", 32'(last_hex), 32'h4321);

    // Reset mid-frame discards partial captures
    show(0, tbl[5], 6); show(1, tbl[6], 6);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs_zero("t5_async");
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("t5_hold");
    @(negedge clk);
    rst_n = 1'b1;
    base = fv_cnt;
    show(2, tbl[9], 6); show(3, tbl[10], 6);
    idle(4);
    chk("t5_partial", 32'(fv_cnt - base), 0);
    show(0, tbl[11], 6); show(1, tbl[12], 6);
    idle(4);
    chk("t5_frames", 32'(fv_cnt - base), 1);
    chk("t5_hex", 32'(last_hex), 32'hA9CB);

    // Decode table: same pattern on every digit
    for (int v = 0; v < 20; v++) begin
      base = fv_cnt;
      for (int d = 0; d < NDIG; d++) show(d, vecs[v].pat, 6);
      idle(4);
      chk("tbl_frames", 32'(fv_cnt - base), 1);
      chk("tbl_hex", 32'(last_hex), 32'({4{vecs[v].nib}}));
      chk("tbl_blank", 32'(last_blank), 32'({4{vecs[v].blk}}));
      chk("tbl_err", 32'(last_err), 32'({4{vecs[v].er}}));
    end

    // Random bus activity against the model
    for (int r = 0; r < 300; r++) begin
      logic [3:0] a;
      logic [6:0] p;
      int len, pick;
      len = $urandom_range(1, 8);
      pick = $urandom_range(0, 9);
      if (pick < 8)       a = ~(4'b0001 << $urandom_range(0, 3));
      else if (pick == 8) a = 4'b1111;
      else                a = 4'($urandom);
      pick = $urandom_range(0, 9);
      if (pick < 7)       p = tbl[$urandom_range(0, 15)];
      else if (pick == 7) p = 7'b0;
      else                p = 7'($urandom);
      for (int i = 0; i < len; i++) cyc(a, ~p);
    end
    idle(6);
    chk("rand_frames", 32'(fv_cnt), 32'(m_frames));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
